// File: rtl/register_shadow_pkg.sv
// ---------------------------------------------------------------------------
// register_shadow_pkg
// Shared definitions for the register shadow stack.
//   SHADOW_RESET        : reset/cleared value of one active-low byte (logical 0)
//   DEFAULT_DEPTH       : default number of shadow banks
//   shadow_entry_t      : one 24-bit active-low bank entry, packed as {a, b, c}
//   SHADOW_ENTRY_RESET  : a whole entry at its reset/cleared value
// ---------------------------------------------------------------------------
package register_shadow_pkg;

    localparam logic [7:0] SHADOW_RESET  = 8'hFF;
    localparam int         DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
    } shadow_entry_t;

    localparam shadow_entry_t SHADOW_ENTRY_RESET = '{
        a: SHADOW_RESET,
        b: SHADOW_RESET,
        c: SHADOW_RESET
    };

endpackage

// File: rtl/register_shadow_entry.sv
// ---------------------------------------------------------------------------
// register_shadow_entry
// One shadow bank: a 24-bit active-low {A, B, C} register.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset, loads SHADOW_ENTRY_RESET
//   we_i   : capture d_i on the edge
//   clr_i  : synchronous clear to SHADOW_ENTRY_RESET
//   d_i    : captured value (active-low working registers)
//   q_o    : stored value
// ---------------------------------------------------------------------------
module register_shadow_entry
    import register_shadow_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic          clr_i,
    input  shadow_entry_t d_i,
    output shadow_entry_t q_o
);

    shadow_entry_t entry_q;
    shadow_entry_t entry_d;

    // The top never writes and clears the same bank on one edge (a capture
    // targets the current level, a clear targets the next one), so the
    // priority here only matters for standalone reuse: capture wins.
    always_comb begin
        entry_d = entry_q;
        if (we_i) begin
            entry_d = d_i;
        end else if (clr_i) begin
            entry_d = SHADOW_ENTRY_RESET;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            entry_q <= SHADOW_ENTRY_RESET;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q_o = entry_q;

endmodule

// File: rtl/register_shadow_stack.sv
// ---------------------------------------------------------------------------
// register_shadow_stack
// Shadow-side partner of the A/B/C working registers. On PR_Ex the current
// bank captures the working registers while those registers load the
// (pre-edge) shadow outputs, giving a true swap. DEPTH banks selected by a
// level pointer let nested contexts each keep their own shadow set.
//   Clk, Rst               : clock / asynchronous active-high reset
//   notA, notB, notC       : working registers, active-low
//   PR_Ex                  : exchange strobe
//   PR_Push, PR_Pop        : open a new level / return to the previous one
//   ClrErr                 : clears the sticky error flags
//   notShadowA/B/C         : active bank contents, active-low, registered
//   Level, Empty, Full     : level pointer and its limits
//   Overflow, Underflow    : sticky push-while-Full / pop-while-Empty
// ---------------------------------------------------------------------------
module register_shadow_stack
    import register_shadow_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int LW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [7:0]    notA,
    input  logic [7:0]    notB,
    input  logic [7:0]    notC,
    input  logic          PR_Ex,
    input  logic          PR_Push,
    input  logic          PR_Pop,
    input  logic          ClrErr,
    output logic [7:0]    notShadowA,
    output logic [7:0]    notShadowB,
    output logic [7:0]    notShadowC,
    output logic [LW-1:0] Level,
    output logic          Empty,
    output logic          Full,
    output logic          Overflow,
    output logic          Underflow
);

    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          overflow_q;
    logic          overflow_d;
    logic          underflow_q;
    logic          underflow_d;

    logic          empty;
    logic          full;
    logic          push_only;
    logic          pop_only;
    logic          push_ok;
    logic          pop_ok;
    logic [LW-1:0] level_next_up;

    shadow_entry_t capture;
    shadow_entry_t bank_q [DEPTH];

    assign empty         = (level_q == '0);
    assign full          = (level_q == LW'(DEPTH - 1));
    // Push and Pop together cancel: no movement, no clear, no error.
    assign push_only     = PR_Push & ~PR_Pop;
    assign pop_only      = PR_Pop & ~PR_Push;
    assign push_ok       = push_only & ~full;
    assign pop_ok        = pop_only & ~empty;
    assign level_next_up = level_q + LW'(1);

    assign capture = '{a: notA, b: notB, c: notC};

    // Capture always lands in the bank selected before the edge, so Ex
    // combined with Push/Pop stores into the old level and then moves.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bank
        register_shadow_entry u_entry (
            .clk_i (Clk),
            .rst_i (Rst),
            .we_i  (PR_Ex && (level_q == LW'(gi))),
            .clr_i (push_ok && (level_next_up == LW'(gi))),
            .d_i   (capture),
            .q_o   (bank_q[gi])
        );
    end

    always_comb begin
        level_d = level_q;
        if (push_ok) begin
            level_d = level_next_up;
        end else if (pop_ok) begin
            level_d = level_q - LW'(1);
        end
    end

    // A fresh error in the ClrErr cycle takes precedence over the clear.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (ClrErr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (push_only && full) begin
            overflow_d = 1'b1;
        end
        if (pop_only && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Outputs come from registered state only; the working registers
    // sample these pre-edge values during an exchange.
    assign notShadowA = bank_q[level_q].a;
    assign notShadowB = bank_q[level_q].b;
    assign notShadowC = bank_q[level_q].c;
    assign Level      = level_q;
    assign Empty      = empty;
    assign Full       = full;
    assign Overflow   = overflow_q;
    assign Underflow  = underflow_q;

endmodule

// File: tb/tb_register_shadow_stack.sv
module tb_register_shadow_stack;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [7:0] notA = 8'hFF;
    logic [7:0] notB = 8'hFF;
    logic [7:0] notC = 8'hFF;
    logic       PR_Ex = 1'b0;
    logic       PR_Push = 1'b0;
    logic       PR_Pop = 1'b0;
    logic       ClrErr = 1'b0;
    logic [7:0] notShadowA;
    logic [7:0] notShadowB;
    logic [7:0] notShadowC;
    logic [1:0] Level;
    logic       Empty;
    logic       Full;
    logic       Overflow;
    logic       Underflow;

    int errors = 0;
    int checks = 0;

    register_shadow_stack #(.DEPTH(4), .LW(2)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .notA       (notA),
        .notB       (notB),
        .notC       (notC),
        .PR_Ex      (PR_Ex),
        .PR_Push    (PR_Push),
        .PR_Pop     (PR_Pop),
        .ClrErr     (ClrErr),
        .notShadowA (notShadowA),
        .notShadowB (notShadowB),
        .notShadowC (notShadowC),
        .Level      (Level),
        .Empty      (Empty),
        .Full       (Full),
        .Overflow   (Overflow),
        .Underflow  (Underflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One edge with the given strobes, then strobes drop; outputs are
    // sampled 1 time unit after the edge.
    task automatic tick(input logic ex, input logic push, input logic pop, input logic clr);
        PR_Ex = ex; PR_Push = push; PR_Pop = pop; ClrErr = clr;
        @(posedge Clk);
        #1;
        PR_Ex = 1'b0; PR_Push = 1'b0; PR_Pop = 1'b0; ClrErr = 1'b0;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        notA = a; notB = b; notC = c;
    endtask

    function automatic logic [23:0] shadows();
        return {notShadowA, notShadowB, notShadowC};
    endfunction

    function automatic logic [23:0] status();
        return {16'h0, 2'b0, Level, Empty, Full, Overflow, Underflow};
    endfunction

    // status packing: {Level[1:0], Empty, Full, Overflow, Underflow}
    function automatic logic [23:0] st(input logic [1:0] lvl, input logic e, input logic f,
                                       input logic o, input logic u);
        return {16'h0, 2'b0, lvl, e, f, o, u};
    endfunction

    initial begin
        // Reset, then idle
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        tick(0, 0, 0, 0);
        check("reset_shadows", shadows(), 24'hFFFFFF);
        check("reset_status", status(), st(2'd0, 1, 0, 0, 0));
        $display("txn reset: shadows=%06h level=%0d", shadows(), Level);

        // Simple exchange at level 0
        drive(8'hA5, 8'h3C, 8'h0F);
        tick(1, 0, 0, 0);
        check("ex_l0_shadows", shadows(), 24'hA53C0F);
        check("ex_l0_level", status(), st(2'd0, 1, 0, 0, 0));
        $display("txn ex: shadows=%06h level=%0d", shadows(), Level);

        // Push opens a fresh bank
        drive(8'h00, 8'h00, 8'h00);
        tick(0, 1, 0, 0);
        check("push_fresh", shadows(), 24'hFFFFFF);
        check("push_status", status(), st(2'd1, 0, 0, 0, 0));
        $display("txn push: shadows=%06h level=%0d", shadows(), Level);

        drive(8'h11, 8'h22, 8'h33);
        tick(1, 0, 0, 0);
        check("ex_l1_shadows", shadows(), 24'h112233);
        check("ex_l1_level", status(), st(2'd1, 0, 0, 0, 0));
        $display("txn ex: shadows=%06h level=%0d", shadows(), Level);

        tick(0, 0, 1, 0);
        check("pop_shadows", shadows(), 24'hA53C0F);
        check("pop_status", status(), st(2'd0, 1, 0, 0, 0));
        $display("txn pop: shadows=%06h level=%0d", shadows(), Level);

        // Fill to DEPTH, then overflow
        tick(0, 1, 0, 0);
        check("refill_l1_cleared", shadows(), 24'hFFFFFF);
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        check("full_status", status(), st(2'd3, 0, 1, 0, 0));
        $display("txn push x3: level=%0d full=%0b", Level, Full);
        tick(0, 1, 0, 0);
        check("overflow_status", status(), st(2'd3, 0, 1, 1, 0));
        $display("txn push full: level=%0d ovf=%0b", Level, Overflow);
        tick(0, 0, 0, 1);
        check("clr_overflow", status(), st(2'd3, 0, 1, 0, 0));
        $display("txn clrerr: ovf=%0b", Overflow);

        // Back down to level 0; popped banks keep their contents
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        check("down_l0_shadows", shadows(), 24'hA53C0F);
        check("down_l0_status", status(), st(2'd0, 1, 0, 0, 0));

        // Underflow, and a new error beating ClrErr
        tick(0, 0, 1, 0);
        check("underflow_status", status(), st(2'd0, 1, 0, 0, 1));
        $display("txn pop empty: level=%0d unf=%0b", Level, Underflow);
        tick(0, 0, 1, 1);
        check("err_beats_clr", status(), st(2'd0, 1, 0, 0, 1));
        tick(0, 0, 0, 1);
        check("clr_underflow", status(), st(2'd0, 1, 0, 0, 0));
        $display("txn clrerr: unf=%0b", Underflow);

        // Push and Pop together at level 1
        tick(0, 1, 0, 0);
        tick(0, 1, 1, 0);
        check("push_pop_same", status(), st(2'd1, 0, 0, 0, 0));
        $display("txn push+pop: level=%0d", Level);

        // Ex+Push: capture into level 1, move to cleared level 2
        drive(8'h77, 8'h88, 8'h99);
        tick(1, 1, 0, 0);
        check("expush_shadows", shadows(), 24'hFFFFFF);
        check("expush_level", status(), st(2'd2, 0, 0, 0, 0));
        $display("txn ex+push: shadows=%06h level=%0d", shadows(), Level);

        // Ex+Pop: capture into level 2, return to level 1's saved data
        drive(8'h44, 8'h55, 8'h66);
        tick(1, 0, 1, 0);
        check("expop_shadows", shadows(), 24'h778899);
        check("expop_level", status(), st(2'd1, 0, 0, 0, 0));
        $display("txn ex+pop: shadows=%06h level=%0d", shadows(), Level);

        // Ex+Push while Full: capture happens, Overflow set, Level held
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        drive(8'hDE, 8'hAD, 8'hBE);
        tick(1, 1, 0, 0);
        check("expush_full_shadows", shadows(), 24'hDEADBE);
        check("expush_full_status", status(), st(2'd3, 0, 1, 1, 0));
        $display("txn ex+push full: shadows=%06h level=%0d ovf=%0b", shadows(), Level, Overflow);

        // Load level 2, then reset asynchronously mid-cycle
        tick(0, 0, 1, 0);
        drive(8'h12, 8'h34, 8'h56);
        tick(1, 0, 0, 0);
        check("pre_rst_shadows", shadows(), 24'h123456);
        check("pre_rst_status", status(), st(2'd2, 0, 0, 1, 0));
        #2 Rst = 1'b1;
        #1;
        check("async_rst_shadows", shadows(), 24'hFFFFFF);
        check("async_rst_status", status(), st(2'd0, 1, 0, 0, 0));
        $display("txn async reset: shadows=%06h level=%0d", shadows(), Level);
        #1 Rst = 1'b0;
        tick(0, 0, 0, 0);
        check("post_rst_status", status(), st(2'd0, 1, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
